// File: rtl/priority_grant_pkg.sv
// Shared types and helpers for the priority grant sequencer.
package priority_grant_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 256;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  // OR of set-bit positions; exact for a one-hot (or zero) input.
  function automatic logic [7:0] onehot_to_index(input logic [MAX_WIDTH-1:0] onehot);
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (onehot[i]) idx = idx | 8'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_onehot_pick.sv
// One-hot of the highest set bit of i_vec, or of the lowest when
// PRIORITY_GRANT_SEQUENCER_LSB_FIRST_EN is defined. Purely combinational.
module priority_onehot_pick #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_onehot
);

  logic w_found;

  always_comb begin
    o_onehot = '0;
    w_found  = 1'b0;
`ifdef PRIORITY_GRANT_SEQUENCER_LSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
`endif
      if (i_vec[i] && !w_found) begin
        o_onehot[i] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_grant_sequencer.sv
// Drains an accepted request vector as one-hot grants, one per output handshake.
// MSB first by default; PRIORITY_GRANT_SEQUENCER_LSB_FIRST_EN selects LSB first.
module priority_grant_sequencer
  import priority_grant_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_grant,
  output logic [IDXW-1:0]  out_index,
  output logic             out_last,
  output logic             busy
);

  state_e           r_state;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] w_pick;
  logic             w_serve;
  logic             w_last;
  logic             w_accept;
  logic             w_fire;

  priority_onehot_pick #(.WIDTH(WIDTH)) u_pick (
    .i_vec    (r_pending),
    .o_onehot (w_pick)
  );

  assign w_serve = (r_state == SERVE);
  // Exactly one bit pending when the picked bit is the whole register.
  assign w_last  = w_serve && (r_pending == w_pick);

  assign in_ready  = !w_serve || (out_ready && w_last);
  assign out_valid = w_serve;
  assign out_grant = w_serve ? w_pick : '0;
  assign out_index = w_serve ? IDXW'(onehot_to_index(MAX_WIDTH'(w_pick))) : '0;
  assign out_last  = w_last;
  assign busy      = |r_pending;

  assign w_accept = in_valid && in_ready;
  assign w_fire   = w_serve && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
    end else if (w_accept) begin
      // Accept while serving only happens on the last grant, so overwriting is safe.
      r_pending <= in_vec;
      r_state   <= (in_vec != '0) ? SERVE : IDLE;
    end else if (w_fire) begin
      r_pending <= r_pending & ~w_pick;
      if (w_last) r_state <= IDLE;
    end
  end

endmodule

// File: tb/tb_priority_grant_sequencer.sv
// Directed bench for priority_grant_sequencer; expectations follow the
// PRIORITY_GRANT_SEQUENCER_LSB_FIRST_EN setting of the build.
module tb_priority_grant_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_grant;
  logic [2:0] out_index;
  logic       out_last;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  priority_grant_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_grant (out_grant),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [7:0] g, input int idx, input logic last);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".grant"}, 32'(out_grant), 32'(g));
    chk({tag, ".index"}, 32'(out_index), 32'(idx));
    chk({tag, ".last"},  32'(out_last),  32'(last));
    chk({tag, ".busy"},  32'(busy),      32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"},    32'(out_valid), 32'd0);
    chk({tag, ".busy"},     32'(busy),      32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready),  32'd1);
    chk({tag, ".grant"},    32'(out_grant), 32'd0);
    chk({tag, ".index"},    32'(out_index), 32'd0);
    chk({tag, ".last"},     32'(out_last),  32'd0);
  endtask

  // Hand-computed grant orders per build.
  logic [7:0] e1_g [4];
  int         e1_i [4];
  logic [7:0] e2_g [3];
  int         e2_i [3];
  logic [7:0] e4_g [3];
  int         e4_i [3];
  logic [7:0] e5_g;
  int         e5_i;
  logic [7:0] e6_g [2];
  int         e6_i [2];

  initial begin
`ifdef PRIORITY_GRANT_SEQUENCER_LSB_FIRST_EN
    e1_g = '{8'h01, 8'h02, 8'h08, 8'h40}; e1_i = '{0, 1, 3, 6};
    e2_g = '{8'h01, 8'h04, 8'h20};        e2_i = '{0, 2, 5};
    e4_g = '{8'h02, 8'h20, 8'h80};        e4_i = '{1, 5, 7};
    e5_g = 8'h04;                         e5_i = 2;
    e6_g = '{8'h08, 8'h10};               e6_i = '{3, 4};
`else
    e1_g = '{8'h40, 8'h08, 8'h02, 8'h01}; e1_i = '{6, 3, 1, 0};
    e2_g = '{8'h20, 8'h04, 8'h01};        e2_i = '{5, 2, 0};
    e4_g = '{8'h80, 8'h20, 8'h02};        e4_i = '{7, 5, 1};
    e5_g = 8'h40;                         e5_i = 6;
    e6_g = '{8'h10, 8'h08};               e6_i = '{4, 3};
`endif

    reset = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_idle("reset");

    // Four-bit vector drained at full rate; in_vec changes after accept are ignored.
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1; in_vec = 8'b01001011; out_ready = 1'b1;
    #1 chk("t1.accept_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_vec = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      #1 chk_grant($sformatf("t1.g%0d", k), e1_g[k], e1_i[k], k == 3);
      chk($sformatf("t1.in_ready%0d", k), 32'(in_ready), 32'(k == 3));
      @(negedge clk);
    end
    #1 chk_idle("t1.end");

    // Stall: grant must hold while out_ready is low.
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'b00100101; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk_grant($sformatf("t2.stall%0d", k), e2_g[0], e2_i[0], 1'b0);
      chk($sformatf("t2.stall_rdy%0d", k), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk_grant($sformatf("t2.g%0d", k), e2_g[k], e2_i[k], k == 2);
      @(negedge clk);
    end
    #1 chk_idle("t2.end");

    // Zero vector is accepted and dropped.
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'h00;
    #1 chk("t3.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk_idle("t3.after");

    // Back-to-back: next vector accepted on the last-grant cycle, no bubble.
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'b00100000;
    @(negedge clk);
    in_vec = 8'b10100010;
    #1 chk_grant("t4.single", 8'h20, 5, 1'b1);
    chk("t4.b2b_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_vec = '0;
    for (int k = 0; k < 3; k++) begin
      #1 chk_grant($sformatf("t4.g%0d", k), e4_g[k], e4_i[k], k == 2);
      @(negedge clk);
    end
    #1 chk_idle("t4.end");

    // Reset mid-sequence discards remaining bits.
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'b01010100;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk_grant("t5.first", e5_g, e5_i, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1 chk_idle("t5.post_rst");
    @(negedge clk);
    #1 chk_idle("t5.post_rst2");

    // Two adjacent bits: order depends on build.
    @(negedge clk);
    in_valid = 1'b1; in_vec = 8'b00011000;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 chk_grant($sformatf("t6.g%0d", k), e6_g[k], e6_i[k], k == 1);
      @(negedge clk);
    end
    #1 chk_idle("t6.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
